dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 32, giving the data memory size in bytes; the legal word addresses are 0..MEM_BYTES-4.
REQ-002 The block SHALL have clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have req_a_i / req_b_i, input, 1 bit each: access request from port A (pipeline MEM stage) / port B (debug/DMA loader).
REQ-005 The block SHALL have we_a_i / we_b_i, input, 1 bit each: 1 = word write, 0 = word read.
REQ-006 The block SHALL have addr_a_i / addr_b_i, input, 32 bits each: byte address of the word.
REQ-007 The block SHALL have wdata_a_i / wdata_b_i, input, 32 bits each: write data.
REQ-008 The block SHALL have ack_a_o / ack_b_o, output, 1 bit each: single-cycle completion pulse.
REQ-009 The block SHALL have rdata_a_o / rdata_b_o, output, 32 bits each: read result, valid with ack.
REQ-010 The block SHALL have err_a_o / err_b_o, output, 1 bit each: access rejected, valid with ack.
REQ-011 The block SHALL have mem_addr_o, output, 32 bits, and mem_wdata_o, output, 32 bits: drive the memory address and write-data inputs.
REQ-012 The block SHALL have mem_read_o / mem_write_o, output, 1 bit each: drive the memory MemRead/MemWrite inputs.
REQ-013 The block SHALL have mem_rdata_i, input, 32 bits: the memory read data (little-endian word, combinational).
REQ-014 The block SHALL have busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-016 IDLE: with no request pending, the block SHALL stay in IDLE.
REQ-017 IDLE: with a request, the block SHALL grant one port, latch its we/addr/wdata and the grant id, then go to ACCESS (legal address) or RESP with the error flag set (illegal address).
REQ-018 Arbitration SHALL be round-robin: a single requester wins; when both request, the port not granted last wins; the last-grant pointer SHALL update on every grant.
REQ-019 An address SHALL be illegal when addr[1:0] != 0 or addr > MEM_BYTES-4 (full 32-bit unsigned compare, no wrap).
REQ-020 ACCESS: for exactly one cycle, the block SHALL drive mem_addr_o = latched addr, mem_wdata_o = latched wdata, mem_write_o = we, mem_read_o = !we; the next state SHALL be RESP.
REQ-021 At the end of ACCESS for a read, the block SHALL register mem_rdata_i into the granted port's rdata output.
REQ-022 Outside ACCESS, mem_read_o, mem_write_o, mem_addr_o and mem_wdata_o SHALL be 0.
REQ-023 An illegal access SHALL never assert mem_read_o or mem_write_o.
REQ-024 RESP: the block SHALL pulse the granted port's ack for one cycle, with err = 1 if illegal, else 0; the next state SHALL be IDLE.
REQ-025 Latency SHALL be: request sampled in IDLE at edge N -> ack high during cycle N+2 (legal) or N+1 (illegal); legal throughput is one transaction per 3 cycles.
REQ-026 rdata_x_o SHALL change only on a legal read completion to that port; writes and errors SHALL leave it unchanged.
REQ-027 err_x_o SHALL be meaningful only while ack_x_o is high and 0 otherwise.
REQ-028 A requester SHALL hold req and its operands stable until ack; req still high in the cycle after ack SHALL be treated as a new request.
REQ-029 Operand changes while not granted, or after latching, SHALL have no effect on the access in progress.

Reset
REQ-030 While rst_i is high, the state SHALL be IDLE, all ack/err/mem strobes 0, busy_o 0, rdata_a_o = rdata_b_o = 0, and the last-grant pointer = B (so A wins the first contention).
REQ-031 Reset asserted mid-ACCESS SHALL drop mem_write_o/mem_read_o immediately (asynchronously) and discard the transaction with no ack.

Verification
REQ-032 Write A addr 8 data 0xDEADBEEF, then read A addr 8 -> mem_write_o high one cycle; read ack two cycles after sampling; rdata_a_o = 0xDEADBEEF, err_a_o = 0.
REQ-033 req_a_i and req_b_i both held high with reads from reset -> grants A, B, A, B; ack pulses spaced 3 cycles apart.
REQ-034 Read B addr 30, then addr 6 -> ack_b_o with err_b_o = 1 one cycle after sampling, no mem strobe, rdata_b_o unchanged.
REQ-035 Read A addr 28 (legal boundary) after a write of 0x01020304 there -> rdata_a_o = 0x01020304, err 0; addr 0xFFFFFFFC -> err 1.
REQ-036 rst_i pulsed during ACCESS of a write -> mem_write_o falls within the same cycle, no ack, busy_o 0; the next contention is won by A.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter.
// Port A (pipeline MEM stage) and port B (debug/DMA loader) share a single
// combinational-read, synchronous-write word memory. Each access runs through
// IDLE -> ACCESS -> RESP. An illegal address skips ACCESS, so the memory is
// never strobed for a rejected request. Round-robin arbitration picks a
// winner when both ports request in the same cycle.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req_a_i,
    input  logic        we_a_i,
    input  logic [31:0] addr_a_i,
    input  logic [31:0] wdata_a_i,
    output logic        ack_a_o,
    output logic [31:0] rdata_a_o,
    output logic        err_a_o,

    input  logic        req_b_i,
    input  logic        we_b_i,
    input  logic [31:0] addr_b_i,
    input  logic [31:0] wdata_b_i,
    output logic        ack_b_o,
    output logic [31:0] rdata_b_o,
    output logic        err_b_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o
);

    // Highest legal word address. The compare against it is a full 32-bit
    // unsigned compare, so huge addresses never wrap into the legal range.
    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    state_t      state;
    state_t      state_nxt;

    port_t       last_grant;
    port_t       grant_sel;
    port_t       grant_id;

    logic        any_req;
    logic        take_req;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_illegal;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_err;

    // Round-robin winner: a lone requester wins; on contention the port that
    // was not granted last time wins.
    always_comb begin
        grant_sel = PORT_A;
        if (req_a_i && req_b_i) begin
            grant_sel = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b_i) begin
            grant_sel = PORT_B;
        end
    end

    // Operand mux for the selected port plus the address legality check.
    always_comb begin
        any_req     = req_a_i | req_b_i;
        take_req    = (state == IDLE) && any_req;
        sel_we      = (grant_sel == PORT_B) ? we_b_i    : we_a_i;
        sel_addr    = (grant_sel == PORT_B) ? addr_b_i  : addr_a_i;
        sel_wdata   = (grant_sel == PORT_B) ? wdata_b_i : wdata_a_i;
        sel_illegal = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
    end

    // State register; async reset forces IDLE, which drops every strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and all combinational outputs (memory strobes, ack, err).
    always_comb begin
        state_nxt   = state;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        ack_a_o     = 1'b0;
        ack_b_o     = 1'b0;
        err_a_o     = 1'b0;
        err_b_o     = 1'b0;
        busy_o      = (state != IDLE);

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = sel_illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_o  = lat_addr;
                mem_wdata_o = lat_wdata;
                mem_write_o = lat_we  && !lat_err;
                mem_read_o  = !lat_we && !lat_err;
                state_nxt   = RESP;
            end
            RESP: begin
                if (grant_id == PORT_A) begin
                    ack_a_o = 1'b1;
                    err_a_o = lat_err;
                end else begin
                    ack_b_o = 1'b1;
                    err_b_o = lat_err;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winner's operands and grant id once, when the request is
    // accepted in IDLE; later operand changes cannot disturb the access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_err    <= 1'b0;
            grant_id   <= PORT_A;
            last_grant <= PORT_B;
        end else if (take_req) begin
            lat_we     <= sel_we;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_err    <= sel_illegal;
            grant_id   <= grant_sel;
            last_grant <= grant_sel;
        end
    end

    // Read data is registered at the end of ACCESS into the granted port only;
    // writes and rejected accesses leave both read registers untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_a_o <= 32'd0;
            rdata_b_o <= 32'd0;
        end else if ((state == ACCESS) && !lat_we && !lat_err) begin
            if (grant_id == PORT_A) begin
                rdata_a_o <= mem_rdata_i;
            end else begin
                rdata_b_o <= mem_rdata_i;
            end
        end
    end

endmodule
